// File: rtl/video_multi_rect_read.sv
// Multi-window overlay reader: tracks raster position, issues prioritised FIFO reads and
// composites window pixels over the background. Optional border: VIDEO_MULTI_RECT_BORDER_EN.
module video_multi_rect_read #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WIN = 2,
  parameter logic [DATA_WIDTH-1:0] BORDER_COLOR = {DATA_WIDTH{1'b1}}
) (
  input  logic                       video_clk,
  input  logic                       rst,
  input  logic [NUM_WIN-1:0]         win_enable,
  input  logic [12*NUM_WIN-1:0]      win_left,
  input  logic [12*NUM_WIN-1:0]      win_top,
  input  logic [12*NUM_WIN-1:0]      win_width,
  input  logic [12*NUM_WIN-1:0]      win_height,
  output logic [NUM_WIN-1:0]         read_req,
  input  logic [NUM_WIN-1:0]         read_req_ack,
  output logic [NUM_WIN-1:0]         read_en,
  input  logic [DATA_WIDTH*NUM_WIN-1:0] read_data,
  input  logic                       timing_hs,
  input  logic                       timing_vs,
  input  logic                       timing_de,
  input  logic [DATA_WIDTH-1:0]      timing_data,
  output logic                       hs,
  output logic                       vs,
  output logic                       de,
  output logic [DATA_WIDTH-1:0]      vout_data
);

  logic                  s1_hs, s1_vs, s1_de;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [11:0]           pos_x, pos_y;
  // Set once a de-low cycle is seen, so a line cut short by reset produces no reads.
  logic                  armed;
  logic                  s2_hs, s2_vs, s2_de;
  logic [DATA_WIDTH-1:0] s2_data;
  logic                  s3_hs, s3_vs, s3_de;
  logic [DATA_WIDTH-1:0] s3_data;
  logic [NUM_WIN-1:0]    s3_sel;
  logic [NUM_WIN-1:0]    hit;
  logic [NUM_WIN-1:0]    sel;
  logic [DATA_WIDTH-1:0] pix;
  logic                  vs_fall;
`ifdef VIDEO_MULTI_RECT_BORDER_EN
  logic [NUM_WIN-1:0]    edge_pix;
  logic                  sel_border, s2_border, s3_border;
`endif

  for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
    logic [11:0] left, top, wid, hgt;
    logic [12:0] x_end, y_end;
    assign left  = win_left[12*i +: 12];
    assign top   = win_top[12*i +: 12];
    assign wid   = win_width[12*i +: 12];
    assign hgt   = win_height[12*i +: 12];
    assign x_end = {1'b0, left} + {1'b0, wid};
    assign y_end = {1'b0, top} + {1'b0, hgt};
    assign hit[i] = armed && s1_de && win_enable[i] &&
                    (pos_x >= left) && ({1'b0, pos_x} < x_end) &&
                    (pos_y >= top) && ({1'b0, pos_y} < y_end);
`ifdef VIDEO_MULTI_RECT_BORDER_EN
    assign edge_pix[i] = (pos_x == left) || ({1'b0, pos_x} == x_end - 13'd1) ||
                         (pos_y == top) || ({1'b0, pos_y} == y_end - 13'd1);
`endif
  end

  // Lowest index wins; iterate downwards so the last assignment is the winner.
  always_comb begin
    sel = '0;
`ifdef VIDEO_MULTI_RECT_BORDER_EN
    sel_border = 1'b0;
`endif
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel = '0;
        sel[i] = 1'b1;
`ifdef VIDEO_MULTI_RECT_BORDER_EN
        sel_border = edge_pix[i];
`endif
      end
    end
  end

  always_comb begin
    pix = s3_data;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (s3_sel[i]) pix = read_data[DATA_WIDTH*i +: DATA_WIDTH];
    end
`ifdef VIDEO_MULTI_RECT_BORDER_EN
    if (s3_border) pix = BORDER_COLOR;
`endif
  end

  assign vs_fall = s1_vs && !timing_vs;

  always_ff @(posedge video_clk) begin
    if (rst) begin
      s1_hs <= 1'b0; s1_vs <= 1'b0; s1_de <= 1'b0; s1_data <= '0;
      s2_hs <= 1'b0; s2_vs <= 1'b0; s2_de <= 1'b0; s2_data <= '0;
      s3_hs <= 1'b0; s3_vs <= 1'b0; s3_de <= 1'b0; s3_data <= '0;
      pos_x <= '0; pos_y <= '0; armed <= 1'b0;
      read_en <= '0; s3_sel <= '0; read_req <= '0;
      hs <= 1'b0; vs <= 1'b0; de <= 1'b0; vout_data <= '0;
`ifdef VIDEO_MULTI_RECT_BORDER_EN
      s2_border <= 1'b0; s3_border <= 1'b0;
`endif
    end else begin
      s1_hs <= timing_hs; s1_vs <= timing_vs; s1_de <= timing_de; s1_data <= timing_data;
      if (!timing_de) armed <= 1'b1;

      if (!timing_de || !s1_de) pos_x <= '0;
      else if (pos_x != 12'hFFF) pos_x <= pos_x + 12'd1;

      if (timing_vs && !s1_vs) pos_y <= '0;
      else if (s1_de && !timing_de && pos_y != 12'hFFF) pos_y <= pos_y + 12'd1;

      read_en <= sel;
      s2_hs <= s1_hs; s2_vs <= s1_vs; s2_de <= s1_de; s2_data <= s1_data;
      s3_sel <= read_en;
      s3_hs <= s2_hs; s3_vs <= s2_vs; s3_de <= s2_de; s3_data <= s2_data;
      hs <= s3_hs; vs <= s3_vs; de <= s3_de; vout_data <= pix;
`ifdef VIDEO_MULTI_RECT_BORDER_EN
      s2_border <= sel_border; s3_border <= s2_border;
`endif

      for (int i = 0; i < NUM_WIN; i++) begin
        if (!win_enable[i]) read_req[i] <= 1'b0;
        else if (vs_fall) read_req[i] <= 1'b1;
        else if (read_req_ack[i]) read_req[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_multi_rect_read.sv
// Directed bench for video_multi_rect_read: raster frames, a FIFO model and a per-cycle
// expectation ring compared 2 (read_en) and 4 (outputs) cycles after each input.
module tb_video_multi_rect_read;

  logic        video_clk = 1'b0;
  logic        rst;
  logic [1:0]  win_enable;
  logic [23:0] win_left, win_top, win_width, win_height;
  logic [1:0]  read_req, read_req_ack, read_en;
  logic [31:0] read_data = '0;
  logic        timing_hs, timing_vs, timing_de;
  logic [15:0] timing_data;
  logic        hs, vs, de;
  logic [15:0] vout_data;

  video_multi_rect_read dut (
    .video_clk    (video_clk),
    .rst          (rst),
    .win_enable   (win_enable),
    .win_left     (win_left),
    .win_top      (win_top),
    .win_width    (win_width),
    .win_height   (win_height),
    .read_req     (read_req),
    .read_req_ack (read_req_ack),
    .read_en      (read_en),
    .read_data    (read_data),
    .timing_hs    (timing_hs),
    .timing_vs    (timing_vs),
    .timing_de    (timing_de),
    .timing_data  (timing_data),
    .hs           (hs),
    .vs           (vs),
    .de           (de),
    .vout_data    (vout_data)
  );

  always #5 video_clk = ~video_clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  logic fifo_rst = 1'b0;
  int cl[2], ct[2], cw[2], ch[2];
  int mk[2];
  int ren_cnt[2];
  int both_cnt, border_cnt;
  bit          e_ok[8];
  logic        e_hs[8], e_vs[8], e_de[8];
  logic [15:0] e_data[8];
  logic [1:0]  e_ren[8];
  logic [15:0] fcnt[2];

  // FIFO model: a read strobe seen in one cycle presents the next word in the following cycle.
  always begin
    logic [1:0] seen;
    @(negedge video_clk);
    seen = read_en;
    @(posedge video_clk);
    #2;
    if (fifo_rst) begin
      fcnt[0] = 16'h0;
      fcnt[1] = 16'h0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (seen[i] === 1'b1) begin
          read_data[16*i +: 16] = (i == 0 ? 16'hA000 : 16'hB000) + fcnt[i];
          fcnt[i] = fcnt[i] + 16'h1;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_win(input int i, input bit en, input int l, input int t, input int w,
                         input int h);
    cl[i] = l; ct[i] = t; cw[i] = w; ch[i] = h;
    win_enable[i] = en;
    win_left[12*i +: 12] = l[11:0];
    win_top[12*i +: 12] = t[11:0];
    win_width[12*i +: 12] = w[11:0];
    win_height[12*i +: 12] = h[11:0];
  endtask

  function automatic int winner(input int x, input int y, input logic d);
    if (!d) return -1;
    for (int i = 0; i < 2; i++) begin
      if (win_enable[i] && x >= cl[i] && x < cl[i] + cw[i] && y >= ct[i] && y < ct[i] + ch[i])
        return i;
    end
    return -1;
  endfunction

  // One input cycle: drive, record expectation, compare at negedge, advance past posedge.
  task automatic drive(input logic h, input logic v, input logic d, input int x, input int y);
    int w, s;
    logic [15:0] bg, ev;
    logic [1:0] er;
    bg = d ? {y[3:0], x[11:0]} : 16'h0;
    timing_hs = h; timing_vs = v; timing_de = d; timing_data = bg;
    w = winner(x, y, d);
    ev = bg;
    er = 2'b00;
    if (w >= 0) begin
      er[w] = 1'b1;
      ev = (w == 0 ? 16'hA000 : 16'hB000) + mk[w][15:0];
      mk[w]++;
`ifdef VIDEO_MULTI_RECT_BORDER_EN
      if (x == cl[w] || x == cl[w] + cw[w] - 1 || y == ct[w] || y == ct[w] + ch[w] - 1)
        ev = 16'hFFFF;
`endif
    end
    s = cyc % 8;
    e_ok[s] = chk_en; e_hs[s] = h; e_vs[s] = v; e_de[s] = d; e_data[s] = ev; e_ren[s] = er;
    @(negedge video_clk);
    if (cyc >= 4 && e_ok[(cyc - 4) % 8]) begin
      s = (cyc - 4) % 8;
      check_eq("hs", {31'b0, hs}, {31'b0, e_hs[s]});
      check_eq("vs", {31'b0, vs}, {31'b0, e_vs[s]});
      check_eq("de", {31'b0, de}, {31'b0, e_de[s]});
      check_eq("vout_data", {16'b0, vout_data}, {16'b0, e_data[s]});
    end
    if (cyc >= 2 && e_ok[(cyc - 2) % 8])
      check_eq("read_en", {30'b0, read_en}, {30'b0, e_ren[(cyc - 2) % 8]});
    if (read_en[0] === 1'b1) ren_cnt[0]++;
    if (read_en[1] === 1'b1) ren_cnt[1]++;
    if (read_en === 2'b11) both_cnt++;
    if (de === 1'b1 && vout_data === 16'hFFFF) border_cnt++;
    @(posedge video_clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic clear_counts();
    fifo_rst = 1'b1;
    idle(1);
    fifo_rst = 1'b0;
    mk[0] = 0; mk[1] = 0; ren_cnt[0] = 0; ren_cnt[1] = 0;
    both_cnt = 0; border_cnt = 0;
  endtask

  task automatic frame(input int w, input int h);
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    idle(3);
    for (int y = 0; y < h; y++) begin
      drive(1'b1, 1'b0, 1'b0, 0, 0);
      idle(3);
      for (int x = 0; x < w; x++) drive(1'b0, 1'b0, 1'b1, x, y);
    end
    idle(6);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {16'b0, read_req, read_en, hs, vs, de, 9'b0}, 32'h0);
    check_eq({tag, "_vout"}, {16'b0, vout_data}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    read_req_ack = 2'b00;
    win_enable = 2'b00;
    win_left = '0; win_top = '0; win_width = '0; win_height = '0;
    for (int i = 0; i < 2; i++) begin cl[i] = 0; ct[i] = 0; cw[i] = 0; ch[i] = 0; end
    idle(3);
    check_all_zero("reset_state");
    rst = 1'b0;
    clear_counts();
    chk_en = 1'b1;
    idle(6);

    // Single window (2,1,4,2), window 1 disabled.
    set_win(0, 1'b1, 2, 1, 4, 2);
    set_win(1, 1'b0, 0, 0, 0, 0);
    clear_counts();
    frame(16, 4);
    check_eq("s1_ren0_cnt", ren_cnt[0], 8);
    check_eq("s1_ren1_cnt", ren_cnt[1], 0);

    // Overlap: window 0 shadows window 1 at x=4..7.
    set_win(0, 1'b1, 0, 0, 8, 4);
    set_win(1, 1'b1, 4, 0, 8, 4);
    clear_counts();
    frame(16, 4);
    check_eq("ovl_ren0_cnt", ren_cnt[0], 32);
    check_eq("ovl_ren1_cnt", ren_cnt[1], 16);
    check_eq("ovl_both", both_cnt, 0);

    // Request handshake: set beats a coincident ack; ack alone clears.
    set_win(1, 1'b0, 0, 0, 0, 0);
    read_req_ack = 2'b11;
    idle(2);
    check_eq("req_cleared", {30'b0, read_req}, 32'h0);
    read_req_ack = 2'b00;
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    read_req_ack = 2'b01;
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    check_eq("req_set_wins", {30'b0, read_req}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    check_eq("req_ack_clear", {30'b0, read_req}, 32'h0);
    read_req_ack = 2'b00;
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    idle(3);
    check_eq("req_hold_dis1", {30'b0, read_req}, 32'h1);
    read_req_ack = 2'b01;
    idle(1);
    check_eq("req_ack_clear2", {30'b0, read_req}, 32'h0);
    read_req_ack = 2'b00;

    // Right edge of a 4096-wide line; 13-bit end must not wrap.
    set_win(0, 1'b1, 4090, 0, 10, 1);
    clear_counts();
    frame(4096, 1);
    check_eq("edge_ren0_cnt", ren_cnt[0], 6);

    // Reset mid-line at x=5 inside window (3,0,6,2).
    set_win(0, 1'b1, 3, 0, 6, 2);
    chk_en = 1'b0;
    idle(5);
    clear_counts();
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    idle(3);
    for (int x = 0; x < 5; x++) drive(1'b0, 1'b0, 1'b1, x, 0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 5, 0);
    rst = 1'b0;
    check_all_zero("rst_mid");
    for (int x = 6; x < 10; x++) drive(1'b0, 1'b0, 1'b1, x, 0);
    idle(4);
    check_eq("rst_abort_cnt", ren_cnt[0], 1);
    clear_counts();
    chk_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    idle(3);
    for (int x = 0; x < 16; x++) drive(1'b0, 1'b0, 1'b1, x, 1);
    idle(6);
    check_eq("rst_resume_cnt", ren_cnt[0], 6);

`ifdef VIDEO_MULTI_RECT_BORDER_EN
    set_win(0, 1'b1, 0, 0, 4, 3);
    clear_counts();
    frame(16, 4);
    check_eq("brd_ren0_cnt", ren_cnt[0], 12);
    check_eq("brd_pix_cnt", border_cnt, 10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_multi_rect_read.md
VIDEO_MULTI_RECT_READ -- requirements
Module: video_multi_rect_read

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel width per clock.
REQ-002 SHALL have parameter NUM_WIN, default 2, range 1..4, number of overlay windows; window 0 has highest priority.
REQ-003 SHALL have parameter BORDER_COLOR, default {DATA_WIDTH{1'b1}}, border pixel value; used only with the configuration macro.
REQ-004 SHALL have ports, clock and reset first; reset is synchronous and active-high:
- video_clk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous active-high reset.
- win_enable  in  NUM_WIN  per-window enable.
- win_left, win_top, win_width, win_height  in  12*NUM_WIN each  window i at bits [12i+11:12i].
- read_req  out  NUM_WIN  per-window frame-start request.
- read_req_ack  in  NUM_WIN  per-window request acknowledge.
- read_en  out  NUM_WIN  per-window FIFO read strobe.
- read_data  in  DATA_WIDTH*NUM_WIN  per-window FIFO data; valid 1 cycle after read_en.
- timing_hs, timing_vs, timing_de  in  1 each  input timing.
- timing_data  in  DATA_WIDTH  background pixel.
- hs, vs, de  out  1 each  delayed timing.
- vout_data  out  DATA_WIDTH  composited pixel.

Function
REQ-005 SHALL register the inputs (stage S1) and maintain internal pos_x/pos_y, 12 bits each; no external coordinate generator.
REQ-006 pos_x SHALL be 0 on the first de-high cycle of a line and increment by 1 per de-high cycle; it SHALL clear on the de falling edge.
REQ-007 pos_y SHALL increment on each de falling edge and clear on the timing_vs rising edge; both SHALL saturate at 4095 and not wrap.
REQ-008 Window i SHALL be hit when all of the following hold in S1:
- win_enable[i]=1 and de=1;
- left_i <= pos_x < left_i+width_i;
- top_i <= pos_y < top_i+height_i.
- Sums SHALL be computed in 13 bits.
- width=0 or height=0 SHALL never hit.
REQ-009 read_en SHALL be registered (S2) and one-hot-or-zero: only the lowest-index hit window asserts; overlapped lower-priority windows SHALL NOT be read.
REQ-010 In S3, vout_data source SHALL be read_data of the window read in S2, else background timing_data delayed to S3.
REQ-011 hs, vs, de and vout_data SHALL be registered outputs with a fixed latency of 4 cycles from timing_* inputs.
REQ-012 read_req[i] SHALL set on the timing_vs falling edge when win_enable[i]=1, and clear on read_req_ack[i].
REQ-013 If the set and ack events occur in the same cycle, set SHALL win.
REQ-014 read_req[i] SHALL NOT assert while win_enable[i]=0.
REQ-015 Changing win_* mid-frame SHALL take effect on the next S1 cycle; no shadowing is applied.

Reset
REQ-016 With rst=1 at a video_clk edge, the following SHALL clear to 0 on that edge: read_req, read_en, hs, vs, de, vout_data, pos_x, pos_y and all pipeline registers.
REQ-017 Reset asserted mid-line SHALL abort the line.
REQ-018 After reset release, no read_en SHALL assert before the first de rising edge.

Configuration
REQ-019 Macro VIDEO_MULTI_RECT_BORDER_EN, when defined, SHALL output BORDER_COLOR for the hit window's pixels where pos_x=left, pos_x=left+width-1, pos_y=top or pos_y=top+height-1.
REQ-020 Border pixels SHALL still assert read_en, so FIFO consumption stays width*height.
REQ-021 When the macro is undefined, no border logic SHALL exist and every hit pixel SHALL show read_data.

Verification
REQ-022 Scenario: 16x4 active frame; window 0 = (2,1,4,2), window 1 disabled.
- read_en[0] SHALL assert 8 times, at x=2..5 and y=1..2.
- vout_data SHALL equal read_data in exactly those pixels, 4 cycles after input.
REQ-023 Scenario: windows 0=(0,0,8,4) and 1=(4,0,8,4) overlap.
- read_en[1] SHALL assert only at x=8..11, 16 total.
- read_en[0] SHALL assert 32 times.
- read_en SHALL never be 2'b11.
REQ-024 Scenario: vs falling edge with ack held high the same cycle.
- read_req SHALL be 1 next cycle.
- read_req SHALL clear the cycle after ack is sampled alone.
REQ-025 Scenario: window (4090,0,10,1) on a 4096-wide line.
- Hits SHALL occur at x=4090..4095 only, 6 read_en; no wrap to x=0.
REQ-026 Scenario: rst pulsed mid-line at x=5 inside window.
- All outputs SHALL be 0 the next cycle.
- Counting SHALL resume at x=0 on the next de rising edge.
REQ-027 Scenario (macro defined): window (0,0,4,3).
- Border value SHALL appear at 10 pixels; interior (1..2,1) SHALL show read_data.
- read_en count SHALL be 12.
